// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a multi-cycle
// MDU wait with timeout, plus saturating stall/flush cycle counters.
module hazard_controller #(
    parameter int MDU_TIMEOUT = 40,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_id_ex,
    input  logic [4:0]       Rt_id_ex,
    input  logic [4:0]       Rs_if_id,
    input  logic [4:0]       Rt_if_id,
    input  logic             uses_rt_if_id,
    input  logic             branch_taken_ex,
    input  logic             mdu_start_id,
    input  logic             mdu_done,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             mdu_go,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    // state      | meaning
    // S_RUN      | normal flow; branch flush, load-use detect, MDU launch
    // S_LU_STALL | second cycle of a load-use stall; lu is not re-evaluated
    // S_MDU_WAIT | pipeline frozen until mdu_done or the wait limit
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MDU_WAIT = 2'd2
    } state_t;

    localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_mdu_go;
    logic               r_mdu_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_lu;
    logic               w_pc_write;
    logic               w_ifid_write;
    logic               w_ifid_flush;
    logic               w_idex_bubble;
    logic               w_tmo_hit;

    assign w_lu = MemRead_id_ex && (Rt_id_ex != 5'd0) &&
                  ((Rt_id_ex == Rs_if_id) || (uses_rt_if_id && (Rt_id_ex == Rt_if_id)));

    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_tmo_hit     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_taken_ex) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_next        = S_RUN;
                end else if (w_lu) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_next        = S_LU_STALL;
                end else if (mdu_start_id) begin
                    w_next = S_MDU_WAIT;
                end
            end
            S_LU_STALL: begin
                w_next = S_RUN;
                if (branch_taken_ex) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (mdu_start_id) begin
                    w_next = S_MDU_WAIT;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    w_next = S_RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next    = S_RUN;
                    w_tmo_hit = 1'b1;
                end else begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end
            end
            default: w_next = S_RUN;
        endcase
        // Reset holds the front end frozen with a bubble, independent of state
        if (!rst_n) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_mdu_go      <= 1'b0;
            r_mdu_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state  <= w_next;
            r_mdu_go <= (w_next == S_MDU_WAIT) && (r_state != S_MDU_WAIT);
            if ((w_next == S_MDU_WAIT) && (r_state == S_MDU_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_tmo_hit) begin
                r_mdu_timeout <= 1'b1;
            end
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign PCWrite      = w_pc_write;
    assign IFIDWrite    = w_ifid_write;
    assign IFID_flush   = w_ifid_flush;
    assign IDEX_bubble  = w_idex_bubble;
    assign mdu_go       = r_mdu_go;
    assign mdu_timeout  = r_mdu_timeout;
    assign stall_cycles = r_stall_cnt;
    assign flush_cycles = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table in RUN, directed multi-cycle sequences,
// and randomized cycles against a behavioural model of the stall/flush/MDU rules.
module tb_hazard_controller;

    localparam int T  = 8;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          MemRead_id_ex;
    logic [4:0]    Rt_id_ex;
    logic [4:0]    Rs_if_id;
    logic [4:0]    Rt_if_id;
    logic          uses_rt_if_id;
    logic          branch_taken_ex;
    logic          mdu_start_id;
    logic          mdu_done;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          IFID_flush;
    logic          IDEX_bubble;
    logic          mdu_go;
    logic          mdu_timeout;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_cycles;

    hazard_controller #(.MDU_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MemRead_id_ex   (MemRead_id_ex),
        .Rt_id_ex        (Rt_id_ex),
        .Rs_if_id        (Rs_if_id),
        .Rt_if_id        (Rt_if_id),
        .uses_rt_if_id   (uses_rt_if_id),
        .branch_taken_ex (branch_taken_ex),
        .mdu_start_id    (mdu_start_id),
        .mdu_done        (mdu_done),
        .PCWrite         (PCWrite),
        .IFIDWrite       (IFIDWrite),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .mdu_go          (mdu_go),
        .mdu_timeout     (mdu_timeout),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: cycles already spent waiting on the MDU (-1 when not waiting),
    // whether the previous cycle was a load-use stall, sticky timeout, counter values.
    int m_wait;
    bit m_prev_lu;
    bit m_tmo;
    int m_stall;
    int m_flush;

    typedef struct {
        logic       mr;
        logic [4:0] rt_ex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       br;
        logic       start;
        logic       e_pc;
        logic       e_ifid;
        logic       e_flush;
        logic       e_bub;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clr_in();
        MemRead_id_ex   = 1'b0;
        Rt_id_ex        = 5'd0;
        Rs_if_id        = 5'd0;
        Rt_if_id        = 5'd0;
        uses_rt_if_id   = 1'b0;
        branch_taken_ex = 1'b0;
        mdu_start_id    = 1'b0;
        mdu_done        = 1'b0;
    endtask

    task automatic model_clear();
        m_wait    = -1;
        m_prev_lu = 1'b0;
        m_tmo     = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already applied; sample at the falling edge, then advance one clock.
    task automatic model_cycle(input string tag);
        bit lu;
        bit e_pc, e_ifid, e_fl, e_bub, e_go;
        int nw;
        bit nlu, ntmo;
        @(negedge clk);
        lu = MemRead_id_ex && (Rt_id_ex != 0) &&
             ((Rt_id_ex == Rs_if_id) || (uses_rt_if_id && (Rt_id_ex == Rt_if_id)));
        e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0;
        nw = -1; nlu = 0; ntmo = m_tmo;
        e_go = (m_wait == 0);
        if (m_wait >= 0) begin
            if (mdu_done) begin
                nw = -1;
            end else if (m_wait == T - 1) begin
                ntmo = 1;
            end else begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
                nw = m_wait + 1;
            end
        end else if (branch_taken_ex) begin
            e_fl = 1; e_bub = 1;
        end else if (lu && !m_prev_lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            nlu = 1;
        end else if (mdu_start_id) begin
            nw = 0;
        end
        chk({tag, " PCWrite"}, PCWrite, e_pc);
        chk({tag, " IFIDWrite"}, IFIDWrite, e_ifid);
        chk({tag, " IFID_flush"}, IFID_flush, e_fl);
        chk({tag, " IDEX_bubble"}, IDEX_bubble, e_bub);
        chk({tag, " mdu_go"}, mdu_go, e_go);
        chk({tag, " mdu_timeout"}, mdu_timeout, m_tmo);
        chk({tag, " stall_cycles"}, stall_cycles, m_stall);
        chk({tag, " flush_cycles"}, flush_cycles, m_flush);
        if (!e_pc && m_stall < CMAX) m_stall++;
        if (e_fl && m_flush < CMAX) m_flush++;
        m_wait    = nw;
        m_prev_lu = nlu;
        m_tmo     = ntmo;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 5'd31, 5'd31, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        clr_in();
        model_clear();
        #1;
        chk("rst PCWrite", PCWrite, 0);
        chk("rst IFIDWrite", IFIDWrite, 0);
        chk("rst IFID_flush", IFID_flush, 0);
        chk("rst IDEX_bubble", IDEX_bubble, 1);
        chk("rst mdu_go", mdu_go, 0);
        chk("rst mdu_timeout", mdu_timeout, 0);
        chk("rst stall_cycles", stall_cycles, 0);
        chk("rst flush_cycles", flush_cycles, 0);
        do_reset();

        // RUN-state decode table; an async reset pulse returns to RUN before each vector
        for (int i = 0; i < 10; i++) begin
            tick();
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            MemRead_id_ex   = tbl[i].mr;
            Rt_id_ex        = tbl[i].rt_ex;
            Rs_if_id        = tbl[i].rs;
            Rt_if_id        = tbl[i].rt;
            uses_rt_if_id   = tbl[i].use_rt;
            branch_taken_ex = tbl[i].br;
            mdu_start_id    = tbl[i].start;
            #1;
            chk($sformatf("vec%0d PCWrite", i), PCWrite, tbl[i].e_pc);
            chk($sformatf("vec%0d IFIDWrite", i), IFIDWrite, tbl[i].e_ifid);
            chk($sformatf("vec%0d IFID_flush", i), IFID_flush, tbl[i].e_flush);
            chk($sformatf("vec%0d IDEX_bubble", i), IDEX_bubble, tbl[i].e_bub);
        end

        // Load-use stall lasts one cycle even with the hazard held
        do_reset();
        MemRead_id_ex = 1'b1; Rt_id_ex = 5'd5; Rs_if_id = 5'd5;
        @(negedge clk);
        chk("lu stall PCWrite", PCWrite, 0);
        chk("lu stall IDEX_bubble", IDEX_bubble, 1);
        tick();
        @(negedge clk);
        chk("lu release PCWrite", PCWrite, 1);
        chk("lu release IDEX_bubble", IDEX_bubble, 0);
        chk("lu stall_cycles", stall_cycles, 1);

        // Branch beats load-use and MDU start
        do_reset();
        MemRead_id_ex = 1'b1; Rt_id_ex = 5'd5; Rs_if_id = 5'd5;
        branch_taken_ex = 1'b1; mdu_start_id = 1'b1;
        @(negedge clk);
        chk("prio IFID_flush", IFID_flush, 1);
        chk("prio IDEX_bubble", IDEX_bubble, 1);
        chk("prio PCWrite", PCWrite, 1);
        tick();
        clr_in();
        @(negedge clk);
        chk("prio mdu_go", mdu_go, 0);
        chk("prio flush_cycles", flush_cycles, 1);
        chk("prio PCWrite after", PCWrite, 1);

        // MDU done four cycles after the go pulse
        do_reset();
        mdu_start_id = 1'b1;
        @(negedge clk);
        chk("mdu launch PCWrite", PCWrite, 1);
        tick();
        mdu_start_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mdu wait%0d PCWrite", i), PCWrite, 0);
            chk($sformatf("mdu wait%0d mdu_go", i), mdu_go, (i == 0) ? 1 : 0);
            tick();
        end
        mdu_done = 1'b1;
        @(negedge clk);
        chk("mdu done PCWrite", PCWrite, 1);
        chk("mdu done IDEX_bubble", IDEX_bubble, 0);
        tick();
        mdu_done = 1'b0;
        @(negedge clk);
        chk("mdu after PCWrite", PCWrite, 1);
        chk("mdu after mdu_go", mdu_go, 0);
        chk("mdu stall_cycles", stall_cycles, 4);

        // Timeout: done never arrives
        do_reset();
        mdu_start_id = 1'b1;
        tick();
        mdu_start_id = 1'b0;
        for (int i = 0; i < T - 1; i++) begin
            @(negedge clk);
            chk($sformatf("tmo wait%0d PCWrite", i), PCWrite, 0);
            tick();
        end
        @(negedge clk);
        chk("tmo exit PCWrite", PCWrite, 1);
        chk("tmo exit flag not yet", mdu_timeout, 0);
        tick();
        @(negedge clk);
        chk("tmo flag", mdu_timeout, 1);
        chk("tmo stall_cycles", stall_cycles, T - 1);
        chk("tmo run PCWrite", PCWrite, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("tmo flag held", mdu_timeout, 1);

        // Async reset in the middle of an MDU wait
        mdu_start_id = 1'b1;
        tick();
        mdu_start_id = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst PCWrite", PCWrite, 0);
        chk("arst IFIDWrite", IFIDWrite, 0);
        chk("arst IFID_flush", IFID_flush, 0);
        chk("arst IDEX_bubble", IDEX_bubble, 1);
        chk("arst mdu_go", mdu_go, 0);
        chk("arst mdu_timeout", mdu_timeout, 0);
        chk("arst stall_cycles", stall_cycles, 0);
        chk("arst flush_cycles", flush_cycles, 0);
        tick();
        chk("arst held stall_cycles", stall_cycles, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst release PCWrite", PCWrite, 1);
        chk("arst release mdu_go", mdu_go, 0);
        tick();
        @(negedge clk);
        chk("arst later mdu_go", mdu_go, 0);
        chk("arst later PCWrite", PCWrite, 1);

        // Flush counter saturation
        do_reset();
        branch_taken_ex = 1'b1;
        repeat (CMAX + 6) tick();
        @(negedge clk);
        chk("sat flush_cycles", flush_cycles, CMAX);
        chk("sat stall_cycles", stall_cycles, 0);

        // Randomized cycles against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            MemRead_id_ex   = ($urandom_range(0, 1) == 1);
            Rt_id_ex        = 5'($urandom_range(0, 3));
            Rs_if_id        = 5'($urandom_range(0, 3));
            Rt_if_id        = 5'($urandom_range(0, 3));
            uses_rt_if_id   = ($urandom_range(0, 1) == 1);
            branch_taken_ex = ($urandom_range(0, 5) == 0);
            mdu_start_id    = ($urandom_range(0, 4) == 0);
            mdu_done        = ($urandom_range(0, 5) == 0);
            model_cycle($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
